// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, responder states and the alignment/size check shared by the memory access path
package mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_INV = 2'b11} size_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  function automatic logic is_misaligned(input size_t size, input logic [1:0] a);
    return size == SZ_INV || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: little-endian lane extract/extend (ldata) and store lane merge (mdata) from size, sgn, ofs, rdata, wdata
module mem_lane_unit
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic        sgn,
  input  logic [1:0]  ofs,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask;
  always_comb begin
    sh = {ofs, 3'b000};
    b = 8'(rdata >> sh);
    h = ofs[1] ? rdata[31:16] : rdata[15:0];
    ldata = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
    mask = (size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << sh;
    mdata = (rdata & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_responder.sv
// mem_access_responder: one-at-a-time load/store responder with alignment check and sub-word RMW; req_* in, rsp_* out, mem_* to word memory
module mem_access_responder
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t state;
  size_t size;
  logic sgn, wr, err, wstore;
  logic [1:0] ofs;
  logic [CW-1:0] cnt;
  logic [31:0] ldata, mdata;
  assign req_ready = state == IDLE;
  assign err = is_misaligned(size_t'(req_size), req_addr[1:0]);
  assign wstore = req_write && req_size == SZ_WORD;
  mem_lane_unit lane (.size, .sgn, .ofs, .rdata(mem_rdata), .wdata(mem_wdata), .ldata, .mdata);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      size <= SZ_BYTE;
      sgn <= 1'b0;
      wr <= 1'b0;
      ofs <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      mem_addr <= '0;
      mem_wr <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size <= size_t'(req_size);
          sgn <= req_signed;
          wr <= req_write;
          ofs <= req_addr[1:0];
          cnt <= CW'(MEM_LAT - 1);
          rsp_data <= '0;
          rsp_err <= err;
          rsp_valid <= err;
          if (err) state <= RESP;
          else begin
            mem_addr <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
            mem_wr <= wstore;
            state <= wstore ? WRITE : READ;
          end
        end
        READ: if (cnt == '0) begin
          if (wr) begin
            mem_wdata <= mdata;
            mem_wr <= 1'b1;
            state <= WRITE;
          end else begin
            rsp_data <= ldata;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end else cnt <= cnt - 1'b1;
        WRITE: begin
          mem_wr <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
